core_layer_sequencer: RTL

Control FSM that walks one fully-connected layer through the shared `Core` datapath: for each output group it streams the input chunks through multiply-accumulate, drains the pipeline, runs the sigmoid pass, and writes the result. It sits between the accelerator top-level command logic and `Core`. It drives every `Core` mux-select and sigmoid control, plus the read and write addresses for the input, weight and output buffers. One request runs at a time, under a start/busy/done handshake.

---
 rtl/core_layer_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/core_layer_sequencer.sv
// Layer sequencer for the shared Core datapath: walks every output group through
// MAC, pipeline drain, sigmoid and write-back, driving Core selects and buffer addresses.
module core_layer_sequencer #(
  parameter int CNT_W   = 8,
  parameter int WADDR_W = 16,
  parameter int MUL_LAT = 3,
  parameter int ADD_LAT = 2,
  parameter int SIG_LAT = 4
) (
  input  logic               clk_pll,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_in_chunks,
  input  logic [CNT_W-1:0]   num_out_groups,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   in_addr,
  output logic [WADDR_W-1:0] w_addr,
  output logic [CNT_W-1:0]   out_addr,
  output logic               out_we,
  output logic [1:0]         mul_in_1_mux_sel_left,
  output logic [1:0]         mul_in_1_mux_sel_right,
  output logic [1:0]         mul_in_2_mux_sel,
  output logic               add_in_1_mux_sel_left,
  output logic [1:0]         add_in_1_mux_sel_right,
  output logic [1:0]         add_in_2_mux_sel,
  output logic [1:0]         add_in_2_mid_mux_sel,
  output logic               sigmoid_pipe_mux_sel,
  output logic [1:0]         sigmoid_pipe_extend_controll,
  output logic               sigmoid_output_mux_sel
);

  localparam int DRAIN_LEN = MUL_LAT + ADD_LAT;
  localparam int PH_MAX    = (DRAIN_LEN > SIG_LAT) ? DRAIN_LEN : SIG_LAT;
  localparam int PH_W      = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_SIG, S_WRITE, S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0] mul_in_1_left;
    logic [1:0] mul_in_1_right;
    logic [1:0] mul_in_2;
    logic       add_in_1_left;
    logic [1:0] add_in_1_right;
    logic [1:0] add_in_2;
    logic [1:0] add_in_2_mid;
    logic       sig_pipe;
    logic [1:0] sig_extend;
    logic       sig_out;
  } ctrl_t;

  state_t             state;
  ctrl_t              ctrl;
  logic [CNT_W-1:0]   n_lat;
  logic [CNT_W-1:0]   g_lat;
  logic [CNT_W-1:0]   chunk;
  logic [CNT_W-1:0]   group;
  logic [WADDR_W-1:0] w_cnt;    // next weight address to issue
  logic [PH_W-1:0]    phase;

  // Chunk 0 starts the accumulation from zero/bias; later chunks add onto feedback.
  function automatic ctrl_t mac_ctrl(input logic first);
    ctrl_t c;
    c                = '0;
    c.add_in_1_left  = 1'b1;
    c.add_in_1_right = 2'd1;
    c.add_in_2       = first ? 2'd0 : 2'd1;
    c.add_in_2_mid   = 2'd1;
    return c;
  endfunction

  function automatic ctrl_t drain_ctrl();
    ctrl_t c;
    c              = '0;
    c.add_in_2     = 2'd1;
    c.add_in_2_mid = 2'd1;
    return c;
  endfunction

  function automatic ctrl_t sig_ctrl(input logic last);
    ctrl_t c;
    c            = '0;
    c.sig_pipe   = 1'b1;
    c.sig_extend = 2'd1;
    c.sig_out    = last;
    return c;
  endfunction

  // Outputs are registered alongside the state: each branch loads the values
  // belonging to the state it is about to enter.
  always_ff @(posedge clk_pll or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ctrl     <= '0;
      n_lat    <= '0;
      g_lat    <= '0;
      chunk    <= '0;
      group    <= '0;
      w_cnt    <= '0;
      phase    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_addr  <= '0;
      w_addr   <= '0;
      out_addr <= '0;
      out_we   <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first, branch assignments below override them
      // (last assignment wins), so every register has a defined value each cycle.
      ctrl     <= '0;
      in_addr  <= '0;
      w_addr   <= '0;
      out_addr <= '0;
      out_we   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD;
          else       busy  <= 1'b0;
        end

        S_LOAD: begin
          n_lat <= num_in_chunks;
          g_lat <= num_out_groups;
          chunk <= '0;
          group <= '0;
          w_cnt <= '0;
          if (num_in_chunks == '0 || num_out_groups == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_MAC;
            ctrl  <= mac_ctrl(1'b1);
            w_cnt <= WADDR_W'(1);
          end
        end

        S_MAC: begin
          if (chunk == n_lat - 1'b1) begin
            state <= S_DRAIN;
            phase <= '0;
            ctrl  <= drain_ctrl();
          end else begin
            chunk   <= chunk + 1'b1;
            in_addr <= chunk + 1'b1;
            w_addr  <= w_cnt;
            w_cnt   <= w_cnt + 1'b1;
            ctrl    <= mac_ctrl(1'b0);
          end
        end

        S_DRAIN: begin
          if (phase == PH_W'(DRAIN_LEN - 1)) begin
            state <= S_SIG;
            phase <= '0;
            ctrl  <= sig_ctrl(SIG_LAT == 1);
          end else begin
            phase <= phase + 1'b1;
            ctrl  <= drain_ctrl();
          end
        end

        S_SIG: begin
          if (phase == PH_W'(SIG_LAT - 1)) begin
            state    <= S_WRITE;
            out_we   <= 1'b1;
            out_addr <= group;
          end else begin
            phase <= phase + 1'b1;
            ctrl  <= sig_ctrl(phase == PH_W'(SIG_LAT - 2));
          end
        end

        S_WRITE: begin
          group <= group + 1'b1;
          if (group + 1'b1 == g_lat) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state  <= S_MAC;
            chunk  <= '0;
            w_addr <= w_cnt;
            w_cnt  <= w_cnt + 1'b1;
            ctrl   <= mac_ctrl(1'b1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mul_in_1_mux_sel_left        = ctrl.mul_in_1_left;
  assign mul_in_1_mux_sel_right       = ctrl.mul_in_1_right;
  assign mul_in_2_mux_sel             = ctrl.mul_in_2;
  assign add_in_1_mux_sel_left        = ctrl.add_in_1_left;
  assign add_in_1_mux_sel_right       = ctrl.add_in_1_right;
  assign add_in_2_mux_sel             = ctrl.add_in_2;
  assign add_in_2_mid_mux_sel         = ctrl.add_in_2_mid;
  assign sigmoid_pipe_mux_sel         = ctrl.sig_pipe;
  assign sigmoid_pipe_extend_controll = ctrl.sig_extend;
  assign sigmoid_output_mux_sel       = ctrl.sig_out;

endmodule
